gen_sweep_sequencer: RTL

//  Parametrised sequencer for the cell array. It steps a position index over NUM_POS groups.

---
 rtl/gen_seq_pkg.sv | 17 +
 rtl/gen_sweep_sequencer_if.sv | 29 ++
 rtl/gen_seq_pos_counter.sv | 35 +++
 rtl/gen_sweep_sequencer.sv | 79 +++++++
 4 files changed

// File: rtl/gen_seq_pkg.sv
// Shared types and constants for the sweep sequencer: FSM state encoding and
// the four per-group slot codes.
package gen_seq_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_SETUP = 2'd0;
  localparam slot_t SLOT_LOAD  = 2'd1;
  localparam slot_t SLOT_RUN   = 2'd2;
  localparam slot_t SLOT_STORE = 2'd3;

endpackage

// File: rtl/gen_sweep_sequencer_if.sv
// Control/strobe bundle between the top-level controller (master) and the
// sweep sequencer (slave).
interface gen_sweep_sequencer_if #(
  parameter int POS_W = 2,
  parameter int GEN_W = 16
);

  logic             run_enb;
  logic             free_run;
  logic             step_req;
  logic             write_array;
  logic             run;
  logic             write_mem;
  logic [POS_W-1:0] pos;
  logic             busy;
  logic             sweep_done;
  logic [GEN_W-1:0] gen_count;

  modport master (
    output run_enb, free_run, step_req,
    input  write_array, run, write_mem, pos, busy, sweep_done, gen_count
  );

  modport slave (
    input  run_enb, free_run, step_req,
    output write_array, run, write_mem, pos, busy, sweep_done, gen_count
  );

endinterface

// File: rtl/gen_seq_pos_counter.sv
// Slot/position counter: four slots per group, NUM_POS groups per sweep,
// explicit wrap at the last group; 'last' flags the final slot of a sweep.
module gen_seq_pos_counter
  import gen_seq_pkg::*;
#(
  parameter int NUM_POS = 4,
  parameter int POS_W   = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             advance,
  output slot_t            slot,
  output logic [POS_W-1:0] pos,
  output logic             last
);

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_POS - 1);

  assign last = (slot == SLOT_STORE) && (pos == POS_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (clear) begin
      slot <= SLOT_SETUP;
      pos  <= '0;
    end else if (advance) begin
      slot <= slot + 2'd1;
      if (slot == SLOT_STORE) begin
        pos <= last ? '0 : pos + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gen_sweep_sequencer.sv
// Sweep sequencer for the cell array: IDLE/SWEEP FSM, per-sweep run enable
// latch, slot strobe decode and optional generation counter (GEN_SEQ_COUNT_EN).
module gen_sweep_sequencer
  import gen_seq_pkg::*;
#(
  parameter int NUM_POS = 4,
  parameter int POS_W   = 2,
  parameter int GEN_W   = 16
) (
  input logic                  clk,
  input logic                  reset,
  gen_sweep_sequencer_if.slave bus
);

  state_t           state;
  logic             run_lat;
  slot_t            slot;
  logic [POS_W-1:0] pos;
  logic             last;
  logic             sweeping;

  assign sweeping = (state == ST_SWEEP);

  gen_seq_pos_counter #(
    .NUM_POS (NUM_POS),
    .POS_W   (POS_W)
  ) u_pos_counter (
    .clk     (clk),
    .clear   (reset),
    .advance (sweeping),
    .slot    (slot),
    .pos     (pos),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      run_lat <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.free_run || bus.step_req) state <= ST_SWEEP;
        end
        ST_SWEEP: begin
          // run_enb only matters at the very first slot of each sweep
          if (slot == SLOT_SETUP && pos == '0) run_lat <= bus.run_enb;
          if (last && !bus.free_run) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.write_array = sweeping && (slot == SLOT_LOAD);
  assign bus.run         = sweeping && (slot == SLOT_RUN) && run_lat;
  assign bus.write_mem   = sweeping && (slot == SLOT_STORE);
  assign bus.pos         = pos;
  assign bus.busy        = sweeping;
  assign bus.sweep_done  = sweeping && last;

`ifdef GEN_SEQ_COUNT_EN
  logic [GEN_W-1:0] gen_q;

  // Counts only sweeps that actually evolved the array.
  always_ff @(posedge clk) begin
    if (reset) begin
      gen_q <= '0;
    end else if (sweeping && last && run_lat) begin
      gen_q <= gen_q + 1'b1;
    end
  end

  assign bus.gen_count = gen_q;
`else
  assign bus.gen_count = '0;
`endif

endmodule
